// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// HAZARD_PERF_EN (optional) enables the stall/flush performance counters.
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 4;
  localparam int PERF_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic nop_d;
    logic nop_e;
    logic halted;
  } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Status/control bundle between the datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int PERF_W = PERF_W_DEF
);
  logic [REG_AW-1:0] d_src_a;
  logic [REG_AW-1:0] d_src_b;
  logic              d_use_a;
  logic              d_use_b;
  logic              d_halt;
  logic [REG_AW-1:0] e_dst;
  logic              e_load;
  logic              m_jmp;
  logic              resume;
  logic              stall_f;
  logic              stall_d;
  logic              nop_d;
  logic              nop_e;
  logic              halted;
  logic [PERF_W-1:0] perf_stall;
  logic [PERF_W-1:0] perf_flush;

  modport master (
    output d_src_a, d_src_b, d_use_a, d_use_b, d_halt, e_dst, e_load, m_jmp, resume,
    input  stall_f, stall_d, nop_d, nop_e, halted, perf_stall, perf_flush
  );

  modport slave (
    input  d_src_a, d_src_b, d_use_a, d_use_b, d_halt, e_dst, e_load, m_jmp, resume,
    output stall_f, stall_d, nop_d, nop_e, halted, perf_stall, perf_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use comparator: D reads a register that the load in E is writing.
module hazard_detect #(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] d_src_a_i,
  input  logic [REG_AW-1:0] d_src_b_i,
  input  logic              d_use_a_i,
  input  logic              d_use_b_i,
  input  logic [REG_AW-1:0] e_dst_i,
  input  logic              e_load_i,
  output logic              hazard_o
);
  assign hazard_o = e_load_i & ((d_use_a_i & (d_src_a_i == e_dst_i)) |
                                (d_use_b_i & (d_src_b_i == e_dst_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline controller: load-use stalls, jump squash from M, HALT parking.
// Define HAZARD_PERF_EN to build the saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = PERF_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hazard;
  logic       jmp_eff;
  ctrl_t      ctrl;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .d_src_a_i (bus.d_src_a),
    .d_src_b_i (bus.d_src_b),
    .d_use_a_i (bus.d_use_a),
    .d_use_b_i (bus.d_use_b),
    .e_dst_i   (bus.e_dst),
    .e_load_i  (bus.e_load),
    .hazard_o  (hazard)
  );

  // A jump seen while parked is older than the HALT and has already retired.
  assign jmp_eff = bus.m_jmp && (state_q != ST_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (jmp_eff) begin
      state_d = ST_RUN;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hazard) begin
            if (LOAD_LAT > 1) begin
              state_d = ST_STALL;
              cnt_d   = 3'(LOAD_LAT - 1);
            end
          end else if (bus.d_halt) begin
            state_d = ST_HALT;
          end
        end
        ST_STALL: begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
          end
        end
        ST_HALT: begin
          if (bus.resume) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // On the resume cycle the held HALT in D is overwritten with a bubble.
  always_comb begin
    ctrl = '0;
    if (!rst) begin
      if (jmp_eff) begin
        ctrl.nop_d = 1'b1;
        ctrl.nop_e = 1'b1;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (hazard || bus.d_halt) begin
              ctrl.stall_f = 1'b1;
              ctrl.stall_d = 1'b1;
              ctrl.nop_e   = 1'b1;
            end
          end
          ST_STALL: begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.nop_e   = 1'b1;
          end
          ST_HALT: begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.nop_e   = 1'b1;
            ctrl.halted  = 1'b1;
            ctrl.nop_d   = bus.resume;
          end
          default: ctrl = '0;
        endcase
      end
    end
  end

  assign bus.stall_f = ctrl.stall_f;
  assign bus.stall_d = ctrl.stall_d;
  assign bus.nop_d   = ctrl.nop_d;
  assign bus.nop_e   = ctrl.nop_e;
  assign bus.halted  = ctrl.halted;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_stall_q;
  logic [PERF_W-1:0] perf_flush_q;
  logic              stall_evt;

  // Only load-use stalls are counted; HALT parking is not a hazard stall.
  assign stall_evt = !rst && !jmp_eff &&
                     ((state_q == ST_STALL) || ((state_q == ST_RUN) && hazard));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_evt && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 1'b1;
      if (jmp_eff && !(&perf_flush_q))   perf_flush_q <= perf_flush_q + 1'b1;
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_flush = perf_flush_q;
`else
  assign bus.perf_stall = '0;
  assign bus.perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with LOAD_LAT=1 and LOAD_LAT=3 instances.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(4), .PERF_W(16)) if1 ();
  pipe_hazard_ctrl_if #(.REG_AW(4), .PERF_W(16)) if3 ();

  pipe_hazard_ctrl #(.REG_AW(4), .LOAD_LAT(1), .PERF_W(16)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );
  pipe_hazard_ctrl #(.REG_AW(4), .LOAD_LAT(3), .PERF_W(16)) dut3 (
    .clk (clk), .rst (rst), .bus (if3.slave)
  );

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output vector order: {stall_f, stall_d, nop_d, nop_e, halted}
  function automatic logic [4:0] o1();
    return {if1.stall_f, if1.stall_d, if1.nop_d, if1.nop_e, if1.halted};
  endfunction
  function automatic logic [4:0] o3();
    return {if3.stall_f, if3.stall_d, if3.nop_d, if3.nop_e, if3.halted};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(input int which, input logic [3:0] sa, input logic ua,
                       input logic [3:0] sb, input logic ub, input logic [3:0] ed,
                       input logic el, input logic dh, input logic mj, input logic rs);
    if (which == 1) begin
      if1.d_src_a = sa; if1.d_use_a = ua; if1.d_src_b = sb; if1.d_use_b = ub;
      if1.e_dst = ed; if1.e_load = el; if1.d_halt = dh; if1.m_jmp = mj; if1.resume = rs;
    end else begin
      if3.d_src_a = sa; if3.d_use_a = ua; if3.d_src_b = sb; if3.d_use_b = ub;
      if3.e_dst = ed; if3.e_load = el; if3.d_halt = dh; if3.m_jmp = mj; if3.resume = rs;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(3, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Outputs must be zero under reset even with a jump and a hazard present
    drive(1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_out", 16'(o1()), 16'b00000);
    tick();
    chk("rst_perf", if1.perf_stall | if1.perf_flush, 16'd0);
    rst = 1'b0;
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle", 16'(o1()), 16'b00000);

    // LOAD_LAT=1: single stall cycle on src A match
    tick();
    drive(1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("haz_a", 16'(o1()), 16'b11010);
    tick();
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("haz_a_after", 16'(o1()), 16'b00000);
    drive(1, 4'd0, 1'b0, 4'd3, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("b_unused", 16'(o1()), 16'b00000);
    drive(1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("no_load", 16'(o1()), 16'b00000);
    drive(1, 4'd2, 1'b1, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("haz_b_r15", 16'(o1()), 16'b11010);
    drive(1, 4'd0, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("haz_a_r0", 16'(o1()), 16'b11010);
    drive(1, 4'd1, 1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_nomatch", 16'(o1()), 16'b00000);

    // Jump beats a simultaneous hazard
    drive(1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("jmp_haz", 16'(o1()), 16'b00110);
    tick();
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jmp_after", 16'(o1()), 16'b00000);

    // HALT entry, jump ignored while parked, resume
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("halt_entry", 16'(o1()), 16'b11010);
    tick();
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("halted", 16'(o1()), 16'b11011);
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("halt_jmp", 16'(o1()), 16'b11011);
    tick();
    chk("halt_jmp_next", 16'(o1()), 16'b11011);
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("resume", 16'(o1()), 16'b11111);
    tick();
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resumed", 16'(o1()), 16'b00000);

    // Hazard outranks d_halt; jump outranks d_halt
    drive(1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("haz_halt", 16'(o1()), 16'b11010);
    tick();
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("haz_halt_after", 16'(o1()), 16'b00000);
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("jmp_halt", 16'(o1()), 16'b00110);
    tick();
    drive(1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jmp_halt_after", 16'(o1()), 16'b00000);

    // LOAD_LAT=3: exactly three stall cycles
    drive(3, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("l3_c1", 16'(o3()), 16'b11010);
    tick();
    drive(3, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("l3_c2", 16'(o3()), 16'b11010);
    tick();
    chk("l3_c3", 16'(o3()), 16'b11010);
    tick();
    chk("l3_done", 16'(o3()), 16'b00000);
    chk("l3_perf_stall", if3.perf_stall, PERF ? 16'd3 : 16'd0);

    // Jump aborts a multi-cycle stall
    drive(3, 4'd9, 1'b0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("l3_haz_b", 16'(o3()), 16'b11010);
    tick();
    drive(3, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("l3_stall_jmp", 16'(o3()), 16'b00110);
    tick();
    drive(3, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("l3_jmp_after", 16'(o3()), 16'b00000);
    chk("l3_perf_stall2", if3.perf_stall, PERF ? 16'd4 : 16'd0);
    chk("l3_perf_flush", if3.perf_flush, PERF ? 16'd1 : 16'd0);

    // Asynchronous reset while in STALL with cnt=2
    drive(3, 4'd4, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(3, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("l3_pre_rst", 16'(o3()), 16'b11010);
    rst = 1'b1;
    #1;
    chk("async_rst", 16'(o3()), 16'b00000);
    chk("async_rst_perf", if3.perf_stall | if3.perf_flush, 16'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release", 16'(o3()), 16'b00000);
    tick();
    chk("rst_run", 16'(o3()), 16'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
